// File: rtl/pwm_duty_capture_pkg.sv
// Shared types and defaults for the PWM duty-cycle capture block.
package pwm_duty_capture_pkg;

   localparam int unsigned DefaultWidth   = 8;
   localparam int unsigned DefaultLockCnt = 2;

   typedef enum logic [0:0] {
      StSearch,
      StMeasure
   } state_e;

   // Bits needed for a match counter that saturates at lock_cnt-1.
   function automatic int unsigned match_width(input int unsigned lock_cnt);
      return (lock_cnt > 2) ? $clog2(lock_cnt) : 1;
   endfunction

endpackage

// File: rtl/prim_flop_sr.sv
// Positive-edge flip-flop with synchronous active-high reset.
module prim_flop_sr #(
   parameter int unsigned     Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= ResetValue;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/pwm_edge_detect.sv
// Optional 2-flop synchronizer (PWM_SYNC_EN) followed by a rising-edge detector.
module pwm_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic pwm_in,
   output logic level,
   output logic rise
);

   logic prev_q;

`ifdef PWM_SYNC_EN
   logic [1:0] sync_q;

   prim_flop_sr #(
      .Width      (2),
      .ResetValue (2'b00)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({sync_q[0], pwm_in}),
      .q     (sync_q)
   );

   assign level = sync_q[1];
`else
   assign level = pwm_in;
`endif

   prim_flop_sr #(
      .Width      (1),
      .ResetValue (1'b0)
   ) u_prev (
      .clk   (clk),
      .reset (reset),
      .d     (level),
      .q     (prev_q)
   );

   assign rise = level & ~prev_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures PWM high time per 2^WIDTH-cycle window and reports lock on stable results.
// Define PWM_SYNC_EN to pass pwm_in through a 2-flop synchronizer (+2 cycles latency).
module pwm_duty_capture
   import pwm_duty_capture_pkg::*;
#(
   parameter int unsigned WIDTH    = DefaultWidth,
   parameter int unsigned LOCK_CNT = DefaultLockCnt
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] duty,
   output logic             duty_valid,
   output logic             locked,
   output logic             realign
);

   localparam logic [WIDTH-1:0] MaxCnt  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] LastCnt = MaxCnt - WIDTH'(1);
   localparam int unsigned      MatchW  = match_width(LOCK_CNT);
   localparam logic [MatchW-1:0] MatchTarget = MatchW'(LOCK_CNT - 1);

   logic level;
   logic rise;

   pwm_edge_detect u_edge (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise)
   );

   state_e            state_q;
   logic [WIDTH-1:0]  win_q;
   logic [WIDTH-1:0]  tmo_q;
   logic [WIDTH:0]    high_q;
   logic [MatchW-1:0] match_q;
   logic              have_prev_q;

   logic [WIDTH:0]    high_d;
   logic [WIDTH-1:0]  result;
   logic [MatchW-1:0] match_d;
   logic              lock_d;

   // Candidate report value and the lock bookkeeping it would produce.
   always_comb begin
      high_d  = high_q + {{WIDTH{1'b0}}, level};
      result  = '0;
      match_d = '0;
      if (state_q == StSearch) begin
         result = level ? MaxCnt : '0;
      end else begin
         result = high_d[WIDTH] ? MaxCnt : high_d[WIDTH-1:0];
      end
      if (have_prev_q && (result == duty)) begin
         match_d = (match_q == MatchTarget) ? match_q : match_q + MatchW'(1);
      end
      lock_d = (match_d == MatchTarget);
   end

   // win_q == MaxCnt marks the boundary cycle where the next window's edge belongs;
   // a window runs from win_q == MaxCnt (or the SEARCH edge) through win_q == LastCnt.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StSearch;
         win_q       <= '0;
         tmo_q       <= '0;
         high_q      <= '0;
         match_q     <= '0;
         have_prev_q <= 1'b0;
         duty        <= '0;
         duty_valid  <= 1'b0;
         locked      <= 1'b0;
         realign     <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         realign    <= 1'b0;
         unique case (state_q)
            StSearch: begin
               if (rise) begin
                  state_q <= StMeasure;
                  win_q   <= '0;
                  high_q  <= (WIDTH+1)'(1);
                  tmo_q   <= '0;
               end else if (tmo_q == MaxCnt) begin
                  duty        <= result;
                  duty_valid  <= 1'b1;
                  match_q     <= match_d;
                  locked      <= lock_d;
                  have_prev_q <= 1'b1;
                  tmo_q       <= '0;
               end else begin
                  tmo_q <= tmo_q + WIDTH'(1);
               end
            end
            StMeasure: begin
               if (rise && (win_q != MaxCnt)) begin
                  win_q   <= '0;
                  high_q  <= (WIDTH+1)'(1);
                  realign <= 1'b1;
                  locked  <= 1'b0;
                  match_q <= '0;
               end else begin
                  win_q <= win_q + WIDTH'(1);
                  if (win_q == LastCnt) begin
                     duty        <= result;
                     duty_valid  <= 1'b1;
                     match_q     <= match_d;
                     locked      <= lock_d;
                     have_prev_q <= 1'b1;
                     high_q      <= '0;
                  end else begin
                     high_q <= high_d;
                  end
               end
            end
            default: state_q <= StSearch;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench with a report/realign scoreboard; build with PWM_SYNC_EN for the synced variant.
module tb_pwm_duty_capture;

   localparam int Width   = 8;
   localparam int LockCnt = 2;
   localparam int Period  = 1 << Width;
`ifdef PWM_SYNC_EN
   localparam int Lat = 2;
`else
   localparam int Lat = 0;
`endif

   typedef struct {
      int duty;
      bit locked;
      int cyc;
   } rep_t;

   logic             clk    = 1'b0;
   logic             reset  = 1'b1;
   logic             pwm_in = 1'b0;
   logic [Width-1:0] duty;
   logic             duty_valid;
   logic             locked;
   logic             realign;

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   rep_t rep_q[$];
   int   realign_q[$];
   rep_t mon_r;
   int   mon_c;
   int   mdl_prev  = 0;
   bit   mdl_have  = 1'b0;
   int   mdl_match = 0;
   int   x_edge;

   pwm_duty_capture #(
      .WIDTH    (Width),
      .LOCK_CNT (LockCnt)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .duty_valid (duty_valid),
      .locked     (locked),
      .realign    (realign)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference lock model: consecutive identical reports, saturating at LockCnt-1.
   task automatic exp_report(input int d, input int at);
      rep_t r;
      if (mdl_have && d == mdl_prev) begin
         if (mdl_match < LockCnt - 1) mdl_match++;
      end else begin
         mdl_match = 0;
      end
      mdl_have = 1'b1;
      mdl_prev = d;
      r.duty   = d;
      r.locked = (mdl_match >= LockCnt - 1);
      r.cyc    = at;
      rep_q.push_back(r);
   endtask

   task automatic do_reset(input logic level);
      pwm_in = level;
      reset  = 1'b1;
      repeat (3) tick();
      reset     = 1'b0;
      mdl_have  = 1'b0;
      mdl_match = 0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_duty"}, duty, 0);
      check({tag, "_valid"}, duty_valid, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_realign"}, realign, 0);
   endtask

   // One PWM period starting with a rising edge in the current cycle.
   task automatic pwm_period(input int high, input int len, input bit push);
      int e;
      e = cyc;
      if (push) exp_report((high >= Period) ? Period - 1 : high, e + Period + Lat);
      for (int i = 0; i < len; i++) begin
         pwm_in = (i < high);
         tick();
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * Period && (rep_q.size() > 0 || realign_q.size() > 0); i++) tick();
      tick();
      check("drain_reports", rep_q.size(), 0);
      check("drain_realign", realign_q.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (duty_valid === 1'b1) begin
         if (rep_q.size() == 0) begin
            check("valid_expected", rep_q.size(), 1);
         end else begin
            mon_r = rep_q.pop_front();
            check("valid_cycle", cyc, mon_r.cyc);
            check("duty", duty, mon_r.duty);
            check("locked", locked, mon_r.locked);
         end
      end
      if (realign === 1'b1) begin
         if (realign_q.size() == 0) begin
            check("realign_expected", realign_q.size(), 1);
         end else begin
            mon_c = realign_q.pop_front();
            check("realign_cycle", cyc, mon_c);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, then duty 3 for three periods.
      do_reset(1'b0);
      check_cleared("reset");
      repeat (3) pwm_period(3, Period, 1'b1);
      drain();

      // 0xFF twice then step to 0x0F twice.
      do_reset(1'b0);
      pwm_period(255, Period, 1'b1);
      pwm_period(255, Period, 1'b1);
      pwm_period(15, Period, 1'b1);
      pwm_period(15, Period, 1'b1);
      drain();

      // Input held high from reset: every window saturates.
      do_reset(1'b1);
      exp_report(Period - 1, cyc + Period + Lat);
      exp_report(Period - 1, cyc + 2 * Period + Lat);
      repeat (600) tick();
      drain();

      // Input held low: SEARCH timeout reports zero.
      do_reset(1'b0);
      exp_report(0, cyc + Period);
      exp_report(0, cyc + 2 * Period);
      repeat (2 * Period + 2) tick();
      drain();

      // Extra edge injected 100 cycles into the second window.
      do_reset(1'b0);
      pwm_period(3, Period, 1'b1);
      pwm_period(3, 100, 1'b0);
      x_edge = cyc;
      realign_q.push_back(x_edge + 1 + Lat);
      mdl_match = 0;
      pwm_period(3, Period, 1'b1);
      pwm_period(3, Period, 1'b1);
      drain();

      // Reset 128 cycles into the second window discards it.
      do_reset(1'b0);
      pwm_period(3, Period, 1'b1);
      pwm_period(3, 128, 1'b0);
      check("pre_reset_duty", duty, 3);
      reset = 1'b1;
      tick();
      check_cleared("mid_reset");
      reset     = 1'b0;
      mdl_have  = 1'b0;
      mdl_match = 0;
      repeat (50) tick();
      pwm_period(3, Period, 1'b1);
      pwm_period(3, Period, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_duty_capture.md
PWM_DUTY_CAPTURE -- requirements
Module: pwm_duty_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width; PWM period is 2^WIDTH clk cycles.
REQ-002 SHALL have parameter LOCK_CNT, default 2, number of consecutive equal measurements required to assert locked.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-005 SHALL have port pwm_in, input, 1, PWM waveform to be measured, period 2^WIDTH cycles.
REQ-006 SHALL have port duty, output, WIDTH, last measured high-cycle count, saturated to 2^WIDTH-1.
REQ-007 SHALL have port duty_valid, output, 1, one-cycle pulse when duty updates.
REQ-008 SHALL have port locked, output, 1, high while LOCK_CNT consecutive windows yielded identical duty.
REQ-009 SHALL have port realign, output, 1, one-cycle pulse when a rising edge occurs off the window boundary.

Function
REQ-010 SHALL detect rising edges of the (optionally synchronized) pwm_in by comparing against a one-cycle delayed copy.
REQ-011 SHALL implement states SEARCH, MEASURE.
REQ-012 SEARCH: wait for rising edge; on edge -> MEASURE with window counter = 0 and high counter = 1 (edge cycle counted as high).
REQ-013 SEARCH: if no edge within 2^WIDTH cycles, SHALL report constant level: duty = 0 if pwm_in low, 2^WIDTH-1 if high, pulse duty_valid, restart timeout, stay in SEARCH.
REQ-014 MEASURE: each cycle increment window counter, increment high counter (WIDTH+1 bits) when pwm_in is high.
REQ-015 MEASURE: when window counter reaches 2^WIDTH-1, SHALL load duty = min(high counter, 2^WIDTH-1) and pulse duty_valid in the next cycle, then start the next window back-to-back with no gap cycle.
REQ-016 Latency: duty_valid asserts exactly 2^WIDTH cycles after the window-start rising edge.
REQ-017 A rising edge at window counter != 0 in MEASURE SHALL abort the window (no duty_valid), pulse realign, clear locked, restart the window at that edge.
REQ-018 A rising edge coinciding with window end SHALL complete the window normally and start the next one; no realign.
REQ-019 locked SHALL set when the match counter reaches LOCK_CNT-1 consecutive equal duty results; any differing result resets the match counter and clears locked.
REQ-020 Entering SEARCH through timeout SHALL clear locked; constant-level reports count toward lock like normal measurements.
REQ-021 Counters SHALL wrap only as stated; high counter never exceeds 2^WIDTH.

Reset
REQ-022 On reset: state = SEARCH, duty = 0, duty_valid = 0, locked = 0, realign = 0, all counters and edge register = 0.
REQ-023 Reset mid-window SHALL discard the partial measurement; no duty_valid for it.

Configuration
REQ-024 With PWM_SYNC_EN defined, pwm_in SHALL pass through a 2-flop synchronizer, adding 2 cycles to all input-referenced latencies.
REQ-025 Without PWM_SYNC_EN, pwm_in SHALL be used directly (one edge-detect register only).

Structure
REQ-026 Shared package SHALL hold the state enumeration (SEARCH, MEASURE) and the default WIDTH constant.
REQ-027 Edge detector/synchronizer SHALL be one sub-module, pwm_edge_detect, outputting level and rise pulse.
REQ-028 Flops SHALL use the team's positive-edge flip-flop primitive with synchronous reset.

Verification
REQ-029 Reset, then 8-bit PWM duty 3 (high 3 of 256 cycles) -> first duty_valid 256 cycles after first edge, duty = 3; locked after 2nd window.
REQ-030 Duty 0xFF then step to 0x0F -> duty 0xFF, 0xFF (locked=1), then 0x0F with locked=0, then locked=1 next window.
REQ-031 pwm_in held high 600 cycles from reset -> duty = 0xFF, duty_valid every 256 cycles in SEARCH, locked after 2nd report.
REQ-032 Extra rising edge injected at window counter 100 -> realign pulse, no duty_valid for that window, next valid 256 cycles after injected edge.
REQ-033 Reset asserted at window counter 128 -> outputs cleared next cycle, no duty_valid until 256 cycles after next edge.
REQ-034 Repeat REQ-029 with PWM_SYNC_EN -> identical values, duty_valid delayed 2 cycles.
